// File: rtl/input_conditioner_pkg.sv
// input_conditioner_pkg: default sizes and debounce counter width helper shared by the conditioner files
package input_conditioner_pkg;
  localparam int N_KEY_DEF = 3;
  localparam int N_SW_DEF = 9;
  localparam int DB_CYCLES_DEF = 500000;
  function automatic int cnt_w(input int n);
    return n < 2 ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/input_conditioner_if.sv
// input_conditioner_if: raw pins in (key_n_i, sw_i) and conditioned levels/pulses out (key_n_o, sw_o, key_press_o, key_release_o, sw_change_o)
interface input_conditioner_if import input_conditioner_pkg::*; #(
  parameter int N_KEY = N_KEY_DEF,
  parameter int N_SW = N_SW_DEF
);
  logic [N_KEY-1:0] key_n_i, key_n_o, key_press_o, key_release_o;
  logic [N_SW-1:0] sw_i, sw_o, sw_change_o;
  modport master (output key_n_i, sw_i, input key_n_o, sw_o, key_press_o, key_release_o, sw_change_o);
  modport slave (input key_n_i, sw_i, output key_n_o, sw_o, key_press_o, key_release_o, sw_change_o);
endinterface

// File: rtl/input_conditioner_debounce_bit.sv
// debounce_bit: one channel (clk, rst_n, raw d) -> 2-flop sync, counter debounce, stable level q, one-cycle rise/fall pulses
module debounce_bit import input_conditioner_pkg::*; #(
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  localparam int CW = cnt_w(DB_CYCLES);
  localparam logic [CW-1:0] C_MAX = CW'(DB_CYCLES - 1);
  logic [1:0] sync;
  logic [CW-1:0] c;
  logic s, upd;
  assign s = sync[1];
  assign upd = (s != q) && (c == C_MAX);
  // pulses are registered alongside q so they assert in the cycle q changes
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync <= {2{RESET_VAL}};
      c <= '0;
      q <= RESET_VAL;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sync <= {sync[0], d};
      c <= (s == q || upd) ? '0 : c + 1'b1;
      q <= upd ? s : q;
      rise <= upd & s;
      fall <= upd & ~s;
    end
endmodule

// File: rtl/input_conditioner.sv
// input_conditioner: clk_clk, reset_reset_n, io (slave) -> per-bit debounced key/switch levels with press/release/change pulses
module input_conditioner import input_conditioner_pkg::*; #(
  parameter int N_KEY = N_KEY_DEF,
  parameter int N_SW = N_SW_DEF,
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input logic clk_clk,
  input logic reset_reset_n,
  input_conditioner_if.slave io
);
  logic [N_KEY-1:0] key_q, key_rise, key_fall;
  logic [N_SW-1:0] sw_q, sw_rise, sw_fall;
  for (genvar i = 0; i < N_KEY; i++) begin : g_key
    debounce_bit #(.DB_CYCLES(DB_CYCLES), .RESET_VAL(1'b1)) u_db (
      .clk(clk_clk), .rst_n(reset_reset_n), .d(io.key_n_i[i]),
      .q(key_q[i]), .rise(key_rise[i]), .fall(key_fall[i])
    );
  end
  for (genvar j = 0; j < N_SW; j++) begin : g_sw
    debounce_bit #(.DB_CYCLES(DB_CYCLES), .RESET_VAL(1'b0)) u_db (
      .clk(clk_clk), .rst_n(reset_reset_n), .d(io.sw_i[j]),
      .q(sw_q[j]), .rise(sw_rise[j]), .fall(sw_fall[j])
    );
  end
  assign io.key_n_o = key_q;
  assign io.key_press_o = key_fall;
  assign io.key_release_o = key_rise;
  assign io.sw_o = sw_q;
  assign io.sw_change_o = sw_rise | sw_fall;
endmodule
